// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_subtractor
//   Digit-serial subtractor computing diff = a - b - bin (mod 2^WIDTH) together
//   with the final unsigned borrow. The operands are handled DIGIT bits per
//   clock, least-significant slice first.
//
//   Handshake: start is sampled on a rising clk edge and is accepted only when
//   busy is low (IDLE or DONE). On acceptance a, b and bin are captured. busy
//   stays high for WIDTH/DIGIT cycles. done then pulses for exactly one cycle,
//   and diff/bout (and ovf) hold their value until the next completion. If
//   start is high during the DONE cycle, a new operation begins with no idle
//   cycle in between.
//
//   Parameters:
//     WIDTH  operand/result width, 2..64
//     DIGIT  bits processed per cycle; WIDTH must be a multiple of DIGIT
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     start  request a new subtraction
//     a, b   minuend / subtrahend (WIDTH bits)
//     bin    borrow-in
//     busy   high in RUN
//     done   one-cycle pulse in DONE
//     diff   registered result (WIDTH bits)
//     bout   registered final borrow-out
//     ovf    registered signed overflow (present only with
//            SERIAL_SUB_OVF_FLAG_EN defined)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  // One DIGIT-wide slice of the subtraction; the extra top bit is the borrow.
  logic [DIGIT:0]   slice_full;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    slice_full = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, borrow_q};
    // Result slices enter at the top so the LSB slice ends up at bit 0.
    res_next   = (res_q >> DIGIT)
                 | (WIDTH'(slice_full[DIGIT-1:0]) << (WIDTH - DIGIT));

    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_FLAG_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          res_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        borrow_d = slice_full[DIGIT];
        res_d    = res_next;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          cnt_d   = '0;
          diff_d  = res_next;
          bout_d  = slice_full[DIGIT];
`ifdef SERIAL_SUB_OVF_FLAG_EN
          // Signed overflow = borrow into the MSB xor borrow out of it. The
          // borrow into the MSB is recovered from the MSB sum bit.
          ovf_d   = (a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ slice_full[DIGIT-1])
                    ^ slice_full[DIGIT];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL be declared: default 8, operand/result width in bits, legal range 2..64.
REQ-002 Parameter DIGIT SHALL be declared: default 1, bits subtracted per clock cycle, WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 Port clk  input  1  SHALL be the single clock, all state updating on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port start  input  1  SHALL request a new subtraction, sampled on rising clk.
REQ-006 Port a  input  WIDTH  SHALL be the minuend, captured when start is accepted.
REQ-007 Port b  input  WIDTH  SHALL be the subtrahend, captured when start is accepted.
REQ-008 Port bin  input  1  SHALL be the borrow-in, captured when start is accepted.
REQ-009 Port busy  output  1  SHALL be high while an operation is in progress (RUN state).
REQ-010 Port done  output  1  SHALL pulse high for exactly one cycle when a result becomes valid.
REQ-011 Port diff  output  WIDTH  SHALL carry the registered result a - b - bin modulo 2^WIDTH.
REQ-012 Port bout  output  1  SHALL carry the registered final borrow-out (1 when a < b + bin, unsigned).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 start SHALL be accepted in IDLE or DONE; on acceptance a, b, bin SHALL be latched into internal shift/borrow registers and the FSM SHALL enter RUN.
REQ-015 start SHALL be ignored while in RUN; latched operands SHALL not change.
REQ-016 Each RUN cycle SHALL subtract the least-significant DIGIT-bit slice of the remaining operands using the registered borrow, shift the result slice in, and update the borrow register.
REQ-017 The slice counter SHALL count WIDTH/DIGIT cycles; after the last slice the FSM SHALL enter DONE.
REQ-018 Latency from accepting edge to done-high SHALL be exactly WIDTH/DIGIT + 1 cycles.
REQ-019 diff and bout SHALL update only on the edge entering DONE and SHALL hold that value until the next completion or reset.
REQ-020 DONE SHALL last one cycle, then go to IDLE unless start is high in that cycle, in which case the FSM SHALL go directly to RUN (back-to-back, no bubble).
REQ-021 done SHALL be high only in DONE; busy SHALL be high only in RUN.
REQ-022 The result SHALL be bit-exact with a WIDTH-bit ripple-borrow subtractor for all operands, including a = b with bin = 1 (diff all-ones, bout 1).

Reset
REQ-023 rst_n low SHALL immediately force IDLE, busy 0, done 0, diff 0, bout 0, and clear counter, shift and borrow registers, including mid-RUN.
REQ-024 After rst_n release, the first start edge SHALL be accepted normally; an aborted operation SHALL never produce done.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_FLAG_EN, when defined, SHALL add port ovf  output  1: signed two's-complement overflow of a - b - bin, registered and updated together with diff, reset to 0.
REQ-026 Without SERIAL_SUB_OVF_FLAG_EN the ovf port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-027 WIDTH=8 DIGIT=1: a=0x05 b=0x03 bin=0, start 1 cycle -> busy 8 cycles, done on cycle 9, diff=0x02 bout=0.
REQ-028 WIDTH=8 DIGIT=1: a=0x00 b=0x01 bin=0 -> diff=0xFF bout=1; a=0x3C b=0x3C bin=1 -> diff=0xFF bout=1.
REQ-029 WIDTH=8 DIGIT=4: a=0xA0 b=0x0F bin=0 -> done exactly 3 cycles after accept, diff=0x91 bout=0; start held high in DONE with a=0x10 b=0x20 -> immediate RUN, diff=0xF0 bout=1.
REQ-030 start pulsed again mid-RUN with different operands -> ignored, result matches first operands.
REQ-031 rst_n asserted during cycle 4 of RUN -> all outputs 0 immediately, no done pulse after release.
REQ-032 With SERIAL_SUB_OVF_FLAG_EN, WIDTH=8: a=0x80 b=0x01 bin=0 -> diff=0x7F ovf=1; a=0x7F b=0x01 -> diff=0x7E ovf=0.
